// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch PC stage.
// XLEN/XMSB mirror the global machine-width definitions.
package fetch_pkg;

    localparam int XLEN    = 64;
    localparam int XMSB    = XLEN - 1;
    localparam int INSN_W  = 32;
    localparam int PC_STEP = 4;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        WAIT,
        DROP
    } fetch_state_t;

    // Instruction addresses are word aligned; low two bits are always cleared.
    function automatic logic [XMSB:0] align_pc(input logic [XMSB:0] addr);
        return addr & ~XLEN'(PC_STEP - 1);
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// One-entry instruction buffer between fetch and decode.
// Holds pc/insn stable while valid and not accepted; flush wins over load.
module fetch_buf
    import fetch_pkg::*;
#(
    parameter logic [XMSB:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              flush,
    input  logic [XMSB:0]     ld_pc,
    input  logic [INSN_W-1:0] ld_insn,
    input  logic              ready,
    output logic              valid,
    output logic [XMSB:0]     pc,
    output logic [INSN_W-1:0] insn
);

    logic              vld_p0;
    logic [XMSB:0]     pc_p0;
    logic [INSN_W-1:0] insn_p0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0  <= 1'b0;
            pc_p0   <= RESET_PC;
            insn_p0 <= '0;
        end else begin
            if (flush) begin
                vld_p0 <= 1'b0;
            end else if (load) begin
                vld_p0 <= 1'b1;
            end else if (ready) begin
                vld_p0 <= 1'b0;
            end

            if (load && !flush) begin
                pc_p0   <= ld_pc;
                insn_p0 <= ld_insn;
            end
        end
    end

    assign valid = vld_p0;
    assign pc    = pc_p0;
    assign insn  = insn_p0;

endmodule

// File: rtl/fetch_pc.sv
// Fetch PC stage: one outstanding imem request, redirect handling and
// discard of responses made stale by a trap or branch redirect.
module fetch_pc
    import fetch_pkg::*;
#(
    parameter logic [XMSB:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trap_en,
    input  logic [XMSB:0]     trap_pc,
    input  logic              br_en,
    input  logic [XMSB:0]     br_pc,
    output logic              imem_req,
    output logic [XMSB:0]     imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [INSN_W-1:0] imem_rdata,
    output logic              if_valid,
    output logic [XMSB:0]     if_pc,
    output logic [INSN_W-1:0] if_insn,
    input  logic              if_ready
);

    localparam logic [XMSB:0] STEP = XLEN'(PC_STEP);

    fetch_state_t  state_q, state_d;
    logic [XMSB:0] pc_q, pc_d;

    logic          redirect;
    logic [XMSB:0] target;
    logic          buf_free;
    logic          gnt_acc;
    logic          buf_load;
    logic          buf_flush;

    assign redirect = trap_en | br_en;
    assign target   = align_pc(trap_en ? trap_pc : br_pc);
    assign buf_free = !if_valid || if_ready;

    // Request is held off while the buffer is occupied and not draining, so
    // a returning response always has a free slot to land in.
    assign imem_req  = (state_q == FETCH) && buf_free;
    assign imem_addr = pc_q;
    assign gnt_acc   = imem_req && imem_gnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        buf_load  = 1'b0;
        buf_flush = redirect;

        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end

            FETCH: begin
                if (redirect) begin
                    pc_d    = target;
                    state_d = gnt_acc ? DROP : FETCH;
                end else if (gnt_acc) begin
                    state_d = WAIT;
                end
            end

            WAIT: begin
                if (redirect) begin
                    pc_d    = target;
                    state_d = imem_rvalid ? FETCH : DROP;
                end else if (imem_rvalid) begin
                    buf_load = 1'b1;
                    pc_d     = pc_q + STEP;
                    state_d  = FETCH;
                end
            end

            DROP: begin
                // The outstanding response belongs to a superseded address.
                if (redirect) begin
                    pc_d = target;
                end
                if (imem_rvalid) begin
                    state_d = FETCH;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    fetch_buf #(
        .RESET_PC (RESET_PC)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .load    (buf_load),
        .flush   (buf_flush),
        .ld_pc   (pc_q),
        .ld_insn (imem_rdata),
        .ready   (if_ready),
        .valid   (if_valid),
        .pc      (if_pc),
        .insn    (if_insn)
    );

endmodule

// File: tb/tb_fetch_pc.sv
// Bench for fetch_pc: scripted memory responder plus an expected-delivery queue.
module tb_fetch_pc;

    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        trap_en = 1'b0;
    logic [63:0] trap_pc = '0;
    logic        br_en = 1'b0;
    logic [63:0] br_pc = '0;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        if_valid;
    logic [63:0] if_pc;
    logic [31:0] if_insn;
    logic        if_ready = 1'b1;

    always #5 clk = ~clk;

    fetch_pc #(
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .trap_en     (trap_en),
        .trap_pc     (trap_pc),
        .br_en       (br_en),
        .br_pc       (br_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_insn     (if_insn),
        .if_ready    (if_ready)
    );

    typedef struct {
        logic [63:0] pc;
        logic [31:0] insn;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] gnt_addr_q[$];
    int          gnt_cyc_q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    bit          allow_gnt = 1'b0;
    bit          hold_rsp  = 1'b0;
    bit          nop_mode  = 1'b0;
    int          lat       = 1;
    logic [31:0] salt      = '0;

    bit          pend      = 1'b0;
    logic [31:0] pend_data = '0;
    int          pend_due  = 0;

    function automatic logic [31:0] insn_of(input logic [63:0] a);
        return nop_mode ? 32'h0000_0013 : (a[31:0] ^ 32'h1234_0013);
    endfunction

    task automatic push_exp(input logic [63:0] pc);
        exp_t e;
        e.pc   = pc;
        e.insn = insn_of(pc);
        exp_q.push_back(e);
    endtask

    // One clock cycle: drive memory, monitor deliveries, advance to next negedge.
    task automatic tick();
        exp_t        e;
        bit          g;
        logic [63:0] a_cap;
        #2;
        imem_rvalid = pend && !hold_rsp && (cyc >= pend_due);
        imem_rdata  = imem_rvalid ? pend_data : 32'h0;
        imem_gnt    = allow_gnt && imem_req;
        #1;
        g     = imem_gnt;
        a_cap = imem_addr;
        if (if_valid && if_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL xfer_unexpected: got pc=%h insn=%h, required no delivery", if_pc, if_insn);
            end else begin
                e = exp_q.pop_front();
                if (if_pc !== e.pc || if_insn !== e.insn) begin
                    bad++;
                    $display("FAIL xfer_data: got pc=%h insn=%h, required pc=%h insn=%h",
                             if_pc, if_insn, e.pc, e.insn);
                end
            end
        end
        if (g) begin
            total++;
            if (pend || a_cap[1:0] !== 2'b00) begin
                bad++;
                $display("FAIL grant_legal: got outstanding=%0d addr=%h, required outstanding=0 aligned addr",
                         pend, a_cap);
            end
            gnt_addr_q.push_back(a_cap);
            gnt_cyc_q.push_back(cyc);
        end
        @(posedge clk);
        if (imem_rvalid) pend = 1'b0;
        if (g) begin
            pend      = 1'b1;
            pend_data = insn_of(a_cap) ^ salt;
            pend_due  = cyc + lat;
        end
        cyc++;
        @(negedge clk);
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        trap_en = 1'b0;
        br_en   = 1'b0;
        tick();
        tick();
        pend     = 1'b0;
        hold_rsp = 1'b0;
        salt     = '0;
        lat      = 1;
        gnt_addr_q.delete();
        gnt_cyc_q.delete();
        exp_q.delete();
        rst = 1'b0;
    endtask

    task automatic run_until_empty(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_timeout: got %0d undelivered after %0d cycles, required 0", name, exp_q.size(), n);
        end
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (!imem_req && n < 10) begin
            tick();
            n++;
        end
        total++;
        if (imem_req !== 1'b1) begin
            bad++;
            $display("FAIL %s_req_timeout: got imem_req=%b, required 1", name, imem_req);
        end
    endtask

    task automatic wait_gnt(input string name, input int count);
        int n = 0;
        while (gnt_addr_q.size() < count && n < 10) begin
            tick();
            n++;
        end
        total++;
        if (gnt_addr_q.size() < count) begin
            bad++;
            $display("FAIL %s_gnt_timeout: got %0d grants, required %0d", name, gnt_addr_q.size(), count);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        allow_gnt = 1'b0;
        #1;
        total++;
        if (imem_req !== 1'b0 || imem_addr !== RESET_PC) begin
            bad++;
            $display("FAIL reset_req: got req=%b addr=%h, required req=0 addr=%h", imem_req, imem_addr, RESET_PC);
        end
        total++;
        if (if_valid !== 1'b0 || if_pc !== RESET_PC || if_insn !== 32'h0) begin
            bad++;
            $display("FAIL reset_buf: got valid=%b pc=%h insn=%h, required 0/%h/0", if_valid, if_pc, if_insn, RESET_PC);
        end
        do_reset();
        total++;
        if (imem_req !== 1'b0) begin
            bad++;
            $display("FAIL idle_req: got imem_req=%b, required 0", imem_req);
        end
        tick();
        total++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
            bad++;
            $display("FAIL first_fetch: got req=%b addr=%h, required req=1 addr=%h", imem_req, imem_addr, RESET_PC);
        end
    endtask

    task automatic test_sequential();
        do_reset();
        nop_mode  = 1'b1;
        if_ready  = 1'b1;
        allow_gnt = 1'b1;
        push_exp(64'h8000_0000);
        push_exp(64'h8000_0004);
        push_exp(64'h8000_0008);
        run_until_empty("seq", 40);
        nop_mode = 1'b0;
        total++;
        if (gnt_addr_q.size() < 3) begin
            bad++;
            $display("FAIL seq_grants: got %0d grants, required at least 3", gnt_addr_q.size());
        end else begin
            if (gnt_addr_q[0] !== 64'h8000_0000 || gnt_addr_q[1] !== 64'h8000_0004 ||
                gnt_addr_q[2] !== 64'h8000_0008) begin
                bad++;
                $display("FAIL seq_addrs: got %h %h %h, required 80000000 80000004 80000008",
                         gnt_addr_q[0], gnt_addr_q[1], gnt_addr_q[2]);
            end
            total++;
            if (gnt_cyc_q[1] - gnt_cyc_q[0] != 2 || gnt_cyc_q[2] - gnt_cyc_q[1] != 2) begin
                bad++;
                $display("FAIL seq_rate: got spacing %0d %0d, required 2 2",
                         gnt_cyc_q[1] - gnt_cyc_q[0], gnt_cyc_q[2] - gnt_cyc_q[1]);
            end
        end
    endtask

    task automatic test_trap_in_wait();
        do_reset();
        if_ready  = 1'b1;
        allow_gnt = 1'b1;
        hold_rsp  = 1'b1;
        wait_gnt("trap", 1);
        trap_en = 1'b1;
        trap_pc = 64'h8000_1002;
        tick();
        trap_en = 1'b0;
        total++;
        if (imem_req !== 1'b0 || if_valid !== 1'b0) begin
            bad++;
            $display("FAIL trap_drop: got req=%b valid=%b, required 0 0", imem_req, if_valid);
        end
        hold_rsp = 1'b0;
        push_exp(64'h8000_1000);
        run_until_empty("trap", 20);
        total++;
        if (gnt_addr_q.size() < 2 || gnt_addr_q[1] !== 64'h8000_1000) begin
            bad++;
            $display("FAIL trap_target: got %0d grants last=%h, required second grant at 80001000",
                     gnt_addr_q.size(), gnt_addr_q[gnt_addr_q.size()-1]);
        end
    endtask

    task automatic test_trap_and_branch();
        do_reset();
        if_ready  = 1'b1;
        allow_gnt = 1'b0;
        wait_req("prio");
        trap_en = 1'b1;
        trap_pc = 64'h8000_2000;
        br_en   = 1'b1;
        br_pc   = 64'h8000_3000;
        tick();
        trap_en = 1'b0;
        br_en   = 1'b0;
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 64'h8000_2000) begin
            bad++;
            $display("FAIL prio_addr: got req=%b addr=%h, required req=1 addr=80002000", imem_req, imem_addr);
        end
        allow_gnt = 1'b1;
        push_exp(64'h8000_2000);
        run_until_empty("prio", 20);
        total++;
        if (gnt_addr_q.size() < 1 || gnt_addr_q[0] !== 64'h8000_2000) begin
            bad++;
            $display("FAIL prio_grant: got %0d grants, required first grant at 80002000", gnt_addr_q.size());
        end
    endtask

    task automatic test_backpressure();
        int n = 0;
        do_reset();
        if_ready  = 1'b0;
        allow_gnt = 1'b1;
        push_exp(RESET_PC);
        while (!if_valid && n < 10) begin
            tick();
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (if_valid !== 1'b1 || if_pc !== RESET_PC || if_insn !== insn_of(RESET_PC) || imem_req !== 1'b0) begin
                bad++;
                $display("FAIL stall_hold[%0d]: got valid=%b pc=%h insn=%h req=%b, required 1/%h/%h/0",
                         i, if_valid, if_pc, if_insn, imem_req, RESET_PC, insn_of(RESET_PC));
            end
        end
        if_ready = 1'b1;
        #1;
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 64'h8000_0004) begin
            bad++;
            $display("FAIL stall_release: got req=%b addr=%h, required req=1 addr=80000004", imem_req, imem_addr);
        end
        push_exp(64'h8000_0004);
        run_until_empty("stall", 20);
    endtask

    task automatic test_branch_no_grant();
        do_reset();
        if_ready  = 1'b1;
        allow_gnt = 1'b0;
        wait_req("br");
        for (int i = 0; i < 3; i++) begin
            total++;
            if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
                bad++;
                $display("FAIL br_hold[%0d]: got req=%b addr=%h, required req=1 addr=%h",
                         i, imem_req, imem_addr, RESET_PC);
            end
            if (i == 2) begin
                br_en = 1'b1;
                br_pc = 64'h8000_0100;
            end
            tick();
            br_en = 1'b0;
        end
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 64'h8000_0100) begin
            bad++;
            $display("FAIL br_addr: got req=%b addr=%h, required req=1 addr=80000100", imem_req, imem_addr);
        end
        allow_gnt = 1'b1;
        push_exp(64'h8000_0100);
        run_until_empty("br", 20);
        total++;
        if (gnt_addr_q.size() < 1 || gnt_addr_q[0] !== 64'h8000_0100) begin
            bad++;
            $display("FAIL br_grant: got %0d grants, required first grant at 80000100", gnt_addr_q.size());
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        if_ready  = 1'b1;
        allow_gnt = 1'b1;
        hold_rsp  = 1'b1;
        salt      = 32'hFFFF_0000;
        wait_gnt("rstmid", 1);
        salt = '0;
        rst  = 1'b1;
        #1;
        total++;
        if (imem_req !== 1'b0 || imem_addr !== RESET_PC || if_valid !== 1'b0 ||
            if_pc !== RESET_PC || if_insn !== 32'h0) begin
            bad++;
            $display("FAIL rstmid_values: got req=%b addr=%h valid=%b pc=%h insn=%h, required 0/%h/0/%h/0",
                     imem_req, imem_addr, if_valid, if_pc, if_insn, RESET_PC, RESET_PC);
        end
        tick();
        tick();
        gnt_addr_q.delete();
        rst      = 1'b0;
        hold_rsp = 1'b0;
        tick();
        total++;
        if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
            bad++;
            $display("FAIL rstmid_stale: got valid=%b req=%b addr=%h, required valid=0 req=1 addr=%h",
                     if_valid, imem_req, imem_addr, RESET_PC);
        end
        push_exp(RESET_PC);
        run_until_empty("rstmid", 20);
        total++;
        if (gnt_addr_q.size() < 1 || gnt_addr_q[0] !== RESET_PC) begin
            bad++;
            $display("FAIL rstmid_restart: got %0d grants, required first grant at %h", gnt_addr_q.size(), RESET_PC);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_sequential();
        test_trap_in_wait();
        test_trap_and_branch();
        test_backpressure();
        test_branch_no_grant();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
